// File: rtl/vec_mem_pkg.sv
// Shared definitions for the vector memory sequencer: default widths,
// derived beat count / counter width, and the sequencer state encoding.
// Optional build macro used by the top: VEC_MEM_BYTE_ADDR_EN (byte-addressed memory).
package vec_mem_pkg;

  localparam int VEC_W_DEF  = 128;
  localparam int WORD_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;

  localparam int N_BEATS = VEC_W_DEF / WORD_W_DEF;
  localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } vec_state_t;

endpackage

// File: rtl/vec_word_packer.sv
// Purpose : lane-indexed capture register; writes one word into lane wr_idx when wr_en.
// Latency : lane register updates on the next clk edge; vec_nxt_dat shows the merged value now.
// Backpr. : none, a write is always accepted.
// Ports   : clk, rst (sync, active-high, clears all lanes), wr_en/wr_idx/wr_dat write port,
//           vec_nxt_dat = stored lanes with the current write already merged in.
module vec_word_packer #(
  parameter int LANES  = 4,
  parameter int LANE_W = 32,
  parameter int IDX_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic [LANE_W-1:0]         wr_dat,
  output logic [LANES*LANE_W-1:0]   vec_nxt_dat
);

  logic [LANES*LANE_W-1:0] lanes_q;
  logic [LANES*LANE_W-1:0] lanes_d;

  always_comb begin
    lanes_d = lanes_q;
    if (wr_en) begin
      lanes_d[int'(wr_idx)*LANE_W +: LANE_W] = wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lanes_q <= '0;
    end else begin
      lanes_q <= lanes_d;
    end
  end

  // Exposing the merged view lets the owner latch a complete vector in the
  // same cycle the last lane arrives.
  assign vec_nxt_dat = lanes_d;

endmodule

// File: rtl/vec_mem_sequencer.sv
// Purpose : splits one VEC_W ldrv/strv into WORD_W memory beats and reassembles loads.
// Latency : strv stalls N+1 cycles (beats 1..N, DONE N+1); ldrv stalls N+2 (VecRValid at N+2).
// Backpr. : StallVec freezes F/D/E/M for the whole transfer; new requests only taken in IDLE.
// Ports   : clk, rst (sync, active-high); VecReqM/VecWriteM/BaseAddrM/VecWDataM request from M;
//           MemAddr/MemWE/MemWData/MemRData word memory port (read data one cycle late);
//           VecRData/VecRValid assembled load; StallVec, Busy status.
// Build   : define VEC_MEM_BYTE_ADDR_EN for byte-addressed memory (INC = WORD_W/8, base aligned).
module vec_mem_sequencer
  import vec_mem_pkg::*;
#(
  parameter int VEC_W  = VEC_W_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              VecReqM,
  input  logic              VecWriteM,
  input  logic [ADDR_W-1:0] BaseAddrM,
  input  logic [VEC_W-1:0]  VecWDataM,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWE,
  output logic [WORD_W-1:0] MemWData,
  input  logic [WORD_W-1:0] MemRData,
  output logic [VEC_W-1:0]  VecRData,
  output logic              VecRValid,
  output logic              StallVec,
  output logic              Busy
);

  localparam int NB = VEC_W / WORD_W;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NB - 1);

`ifdef VEC_MEM_BYTE_ADDR_EN
  localparam int INC = WORD_W / 8;
`else
  localparam int INC = 1;
`endif
  localparam logic [ADDR_W-1:0] ADDR_INC  = ADDR_W'(INC);
  // All ones for word addressing; clears the sub-word bits for byte addressing.
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'(INC) - ADDR_W'(1));

  vec_state_t        state_q, state_d;
  logic [CW-1:0]     beat_q, beat_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [VEC_W-1:0]  wvec_q, wvec_d;
  logic [VEC_W-1:0]  vec_rdata_q, vec_rdata_d;
  logic              vec_rvalid_q, vec_rvalid_d;

  logic [CW-1:0]     next_beat;
  logic              cap_vld;
  logic [CW-1:0]     cap_idx;
  logic [VEC_W-1:0]  pack_nxt_dat;

  assign next_beat = beat_q + CW'(1);

  // Outputs are registered: each transition computes what the port shows
  // during the following cycle, so beat k appears in the cycle the FSM is in beat k.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    mem_addr_d   = '0;
    mem_we_d     = 1'b0;
    mem_wdata_d  = '0;
    wvec_d       = wvec_q;
    vec_rdata_d  = vec_rdata_q;
    vec_rvalid_d = 1'b0;
    cap_vld      = 1'b0;
    cap_idx      = '0;

    case (state_q)
      IDLE: begin
        if (VecReqM) begin
          beat_d     = '0;
          mem_addr_d = BaseAddrM & ADDR_MASK;
          wvec_d     = VecWDataM;
          if (VecWriteM) begin
            state_d     = WRITE;
            mem_we_d    = 1'b1;
            mem_wdata_d = VecWDataM[WORD_W-1:0];
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE: begin
        if (beat_q == LAST_BEAT) begin
          state_d = DONE;
        end else begin
          beat_d      = next_beat;
          mem_addr_d  = mem_addr_q + ADDR_INC;
          mem_we_d    = 1'b1;
          mem_wdata_d = wvec_q[int'(next_beat)*WORD_W +: WORD_W];
        end
      end
      READ: begin
        // Read data trails the address by one cycle, so this cycle's
        // MemRData belongs to the previous beat.
        cap_vld = (beat_q != '0);
        cap_idx = beat_q - CW'(1);
        if (beat_q == LAST_BEAT) begin
          state_d = DRAIN;
        end else begin
          beat_d     = next_beat;
          mem_addr_d = mem_addr_q + ADDR_INC;
        end
      end
      DRAIN: begin
        cap_vld      = 1'b1;
        cap_idx      = LAST_BEAT;
        vec_rdata_d  = pack_nxt_dat;
        vec_rvalid_d = 1'b1;
        state_d      = DONE;
      end
      DONE: begin
        // M still holds the finished instruction here, so VecReqM is ignored.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      wvec_q       <= '0;
      vec_rdata_q  <= '0;
      vec_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      wvec_q       <= wvec_d;
      vec_rdata_q  <= vec_rdata_d;
      vec_rvalid_q <= vec_rvalid_d;
    end
  end

  // Lanes assemble here; VecRData only takes the full vector at DRAIN so it
  // keeps the previous load's value while a new load is in flight.
  vec_word_packer #(
    .LANES  (NB),
    .LANE_W (WORD_W),
    .IDX_W  (CW)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (cap_vld),
    .wr_idx      (cap_idx),
    .wr_dat      (MemRData),
    .vec_nxt_dat (pack_nxt_dat)
  );

  assign MemAddr   = mem_addr_q;
  assign MemWE     = mem_we_q;
  assign MemWData  = mem_wdata_q;
  assign VecRData  = vec_rdata_q;
  assign VecRValid = vec_rvalid_q;
  assign Busy      = (state_q != IDLE);
  // The IDLE term is combinational so the requesting instruction is held in its first cycle.
  assign StallVec  = ((state_q == IDLE) && VecReqM) || (state_q == WRITE) ||
                     (state_q == READ) || (state_q == DRAIN);

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer: per-cycle vector table plus hand sequences
// for reset mid-load, post-reset quiet period and unaligned base addressing.
module tb_vec_mem_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         VecReqM;
  logic         VecWriteM;
  logic [31:0]  BaseAddrM;
  logic [127:0] VecWDataM;
  logic [31:0]  MemAddr;
  logic         MemWE;
  logic [31:0]  MemWData;
  logic [31:0]  MemRData;
  logic [127:0] VecRData;
  logic         VecRValid;
  logic         StallVec;
  logic         Busy;

  always #5 clk = ~clk;

  vec_mem_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .VecReqM   (VecReqM),
    .VecWriteM (VecWriteM),
    .BaseAddrM (BaseAddrM),
    .VecWDataM (VecWDataM),
    .MemAddr   (MemAddr),
    .MemWE     (MemWE),
    .MemWData  (MemWData),
    .MemRData  (MemRData),
    .VecRData  (VecRData),
    .VecRValid (VecRValid),
    .StallVec  (StallVec),
    .Busy      (Busy)
  );

`ifdef VEC_MEM_BYTE_ADDR_EN
  localparam logic [31:0] INC  = 32'd4;
  localparam logic [31:0] MASK = 32'hFFFF_FFFC;
`else
  localparam logic [31:0] INC  = 32'd1;
  localparam logic [31:0] MASK = 32'hFFFF_FFFF;
`endif

  localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] W2 = 128'h0DDC0FFE_0BADF00D_CAFEBABE_DEADBEEF;
  localparam logic [127:0] VA = 128'h000000A3_000000A2_000000A1_000000A0;
  localparam logic [127:0] VB = 128'h000000B3_000000B2_000000B1_000000B0;
  localparam logic [127:0] G  = 128'h5A5A5A5A_A5A5A5A5_5A5A5A5A_A5A5A5A5;

  typedef struct {
    logic         rst, req, wr;
    logic [31:0]  base;
    logic [127:0] wdat;
    logic [31:0]  rdat;
    logic [31:0]  e_addr;
    logic         e_we;
    logic [31:0]  e_wdat;
    logic         e_stall, e_busy, e_rvld;
    logic [127:0] e_vec;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  // Address of beat k for a given base.
  function automatic logic [31:0] ba(input logic [31:0] base, input int k);
    return (base & MASK) + INC * 32'(k);
  endfunction

  function automatic void row(input logic r, input logic q, input logic w,
                              input logic [31:0] b, input logic [127:0] wd,
                              input logic [31:0] rd, input logic [31:0] ea,
                              input logic ewe, input logic [31:0] ewd,
                              input logic est, input logic ebs, input logic erv,
                              input logic [127:0] ev);
    vec_t v;
    v.rst = r; v.req = q; v.wr = w; v.base = b; v.wdat = wd; v.rdat = rd;
    v.e_addr = ea; v.e_we = ewe; v.e_wdat = ewd;
    v.e_stall = est; v.e_busy = ebs; v.e_rvld = erv; v.e_vec = ev;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic q, input logic w, input logic [31:0] b,
                       input logic [127:0] wd, input logic [31:0] rd);
    @(negedge clk);
    rst = r; VecReqM = q; VecWriteM = w; BaseAddrM = b; VecWDataM = wd; MemRData = rd;
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] ea, input logic ewe,
                            input logic [31:0] ewd, input logic est, input logic ebs,
                            input logic erv, input logic [127:0] ev);
    chk($sformatf("%s MemAddr", tag), 128'(MemAddr), 128'(ea));
    chk($sformatf("%s MemWE", tag), 128'(MemWE), 128'(ewe));
    chk($sformatf("%s MemWData", tag), 128'(MemWData), 128'(ewd));
    chk($sformatf("%s StallVec", tag), 128'(StallVec), 128'(est));
    chk($sformatf("%s Busy", tag), 128'(Busy), 128'(ebs));
    chk($sformatf("%s VecRValid", tag), 128'(VecRValid), 128'(erv));
    chk($sformatf("%s VecRData", tag), VecRData, ev);
  endtask

  initial begin
    rst = 1'b1; VecReqM = 1'b0; VecWriteM = 1'b0; BaseAddrM = '0; VecWDataM = '0; MemRData = '0;

    // rst req wr base wdat rdat | addr we wdata stall busy rvld vec
    row(1,0,0,32'h0,0,0,                 0,0,0,0,0,0,0);
    row(1,0,0,32'h0,0,0,                 0,0,0,0,0,0,0);
    // strv base 0x10; inputs scrambled mid-transfer must be ignored
    row(0,1,1,32'h10,D1,0,               0,0,0,1,0,0,0);
    row(0,0,1,32'h99,G,0,                ba(32'h10,0),1,32'hCCDDEEFF,1,1,0,0);
    row(0,1,0,32'h77,G,0,                ba(32'h10,1),1,32'h8899AABB,1,1,0,0);
    row(0,0,0,32'h0,0,0,                 ba(32'h10,2),1,32'h44556677,1,1,0,0);
    row(0,0,0,32'h0,0,0,                 ba(32'h10,3),1,32'h00112233,1,1,0,0);
    row(0,0,0,32'h0,0,0,                 0,0,0,0,1,0,0);
    row(0,0,0,32'h0,0,0,                 0,0,0,0,0,0,0);
    // ldrv base 0x20, data A0..A3 in cycles 2..5, VecRValid in cycle 6
    row(0,1,0,32'h20,G,0,                0,0,0,1,0,0,0);
    row(0,0,0,32'h0,0,0,                 ba(32'h20,0),0,0,1,1,0,0);
    row(0,0,0,32'h0,0,32'hA0,            ba(32'h20,1),0,0,1,1,0,0);
    row(0,0,0,32'h0,0,32'hA1,            ba(32'h20,2),0,0,1,1,0,0);
    row(0,0,0,32'h0,0,32'hA2,            ba(32'h20,3),0,0,1,1,0,0);
    row(0,0,0,32'h0,0,32'hA3,            0,0,0,1,1,0,0);
    row(0,0,0,32'h0,0,32'hDEAD,          0,0,0,0,1,1,VA);
    row(0,0,0,32'h0,0,0,                 0,0,0,0,0,0,VA);
    // ldrv base 0x30 with VecReqM held through DONE, then strv base 0x50
    row(0,1,0,32'h30,G,0,                0,0,0,1,0,0,VA);
    row(0,1,0,32'h30,G,0,                ba(32'h30,0),0,0,1,1,0,VA);
    row(0,1,0,32'h30,G,32'hB0,           ba(32'h30,1),0,0,1,1,0,VA);
    row(0,1,0,32'h30,G,32'hB1,           ba(32'h30,2),0,0,1,1,0,VA);
    row(0,1,0,32'h30,G,32'hB2,           ba(32'h30,3),0,0,1,1,0,VA);
    row(0,1,0,32'h30,G,32'hB3,           0,0,0,1,1,0,VA);
    row(0,1,0,32'h30,G,0,                0,0,0,0,1,1,VB);
    row(0,1,1,32'h50,W2,0,               0,0,0,1,0,0,VB);
    row(0,0,0,32'h0,0,0,                 ba(32'h50,0),1,32'hDEADBEEF,1,1,0,VB);
    row(0,0,0,32'h0,0,0,                 ba(32'h50,1),1,32'hCAFEBABE,1,1,0,VB);
    row(0,0,0,32'h0,0,0,                 ba(32'h50,2),1,32'h0BADF00D,1,1,0,VB);
    row(0,0,0,32'h0,0,0,                 ba(32'h50,3),1,32'h0DDC0FFE,1,1,0,VB);
    row(0,0,0,32'h0,0,0,                 0,0,0,0,1,0,VB);
    row(0,0,0,32'h0,0,0,                 0,0,0,0,0,0,VB);
    // strv base 0xFFFFFFFE: address wraps modulo 2^32
    row(0,1,1,32'hFFFF_FFFE,D1,0,        0,0,0,1,0,0,VB);
    row(0,0,0,32'h0,0,0,                 ba(32'hFFFF_FFFE,0),1,32'hCCDDEEFF,1,1,0,VB);
    row(0,0,0,32'h0,0,0,                 ba(32'hFFFF_FFFE,1),1,32'h8899AABB,1,1,0,VB);
    row(0,0,0,32'h0,0,0,                 ba(32'hFFFF_FFFE,2),1,32'h44556677,1,1,0,VB);
    row(0,0,0,32'h0,0,0,                 ba(32'hFFFF_FFFE,3),1,32'h00112233,1,1,0,VB);
    row(0,0,0,32'h0,0,0,                 0,0,0,0,1,0,VB);
    row(0,0,0,32'h0,0,0,                 0,0,0,0,0,0,VB);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].wr, tbl[i].base, tbl[i].wdat, tbl[i].rdat);
      check_outs($sformatf("row%0d", i), tbl[i].e_addr, tbl[i].e_we, tbl[i].e_wdat,
                 tbl[i].e_stall, tbl[i].e_busy, tbl[i].e_rvld, tbl[i].e_vec);
    end

    // Reset asserted in READ cycle 3 of a load: next cycle all outputs clear,
    // VecRData (holding VB) is wiped and VecRValid never pulses afterwards.
    drive(0,1,0,32'h20,G,0);
    check_outs("rstseq c0", 0,0,0,1,0,0,VB);
    drive(0,0,0,32'h0,0,0);
    check_outs("rstseq c1", ba(32'h20,0),0,0,1,1,0,VB);
    drive(0,0,0,32'h0,0,32'h11);
    check_outs("rstseq c2", ba(32'h20,1),0,0,1,1,0,VB);
    drive(1,0,0,32'h0,0,32'h22);
    check_outs("rstseq c3", ba(32'h20,2),0,0,1,1,0,VB);
    drive(0,0,0,32'h0,0,32'h33);
    check_outs("rstseq c4", 0,0,0,0,0,0,0);
    for (int i = 0; i < 6; i++) begin
      drive(0,0,0,32'h0,0,32'h44);
      chk($sformatf("rstseq quiet%0d VecRValid", i), 128'(VecRValid), 128'd0);
      chk($sformatf("rstseq quiet%0d Busy", i), 128'(Busy), 128'd0);
    end

    // Unaligned base 0x43: word mode uses it as-is, byte mode aligns to 0x40, step 4.
    drive(0,1,1,32'h43,D1,0);
    check_outs("b43 c0", 0,0,0,1,0,0,0);
`ifdef VEC_MEM_BYTE_ADDR_EN
    drive(0,0,0,32'h0,0,0); chk("b43 beat0", 128'(MemAddr), 128'h40);
    drive(0,0,0,32'h0,0,0); chk("b43 beat1", 128'(MemAddr), 128'h44);
    drive(0,0,0,32'h0,0,0); chk("b43 beat2", 128'(MemAddr), 128'h48);
    drive(0,0,0,32'h0,0,0); chk("b43 beat3", 128'(MemAddr), 128'h4C);
`else
    drive(0,0,0,32'h0,0,0); chk("b43 beat0", 128'(MemAddr), 128'h43);
    drive(0,0,0,32'h0,0,0); chk("b43 beat1", 128'(MemAddr), 128'h44);
    drive(0,0,0,32'h0,0,0); chk("b43 beat2", 128'(MemAddr), 128'h45);
    drive(0,0,0,32'h0,0,0); chk("b43 beat3", 128'(MemAddr), 128'h46);
`endif
    drive(0,0,0,32'h0,0,0);
    check_outs("b43 done", 0,0,0,0,1,0,0);
    drive(0,0,0,32'h0,0,0);
    check_outs("b43 idle", 0,0,0,0,0,0,0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_mem_sequencer.md
# vec_mem_sequencer

Multi-cycle controller that moves one 128-bit vector between the vector register file and the 32-bit data memory port for `ldrv`/`strv`. It sits in the Memory stage beside the scalar memory path. It splits a vector access into word beats and stalls the pipeline until the transfer completes. For loads, it reassembles the returned words into a vector for writeback.

## Interface
Parameters:
- VEC_W, 128, vector width in bits
- WORD_W, 32, memory port width in bits; VEC_W must be a multiple of WORD_W
- ADDR_W, 32, memory address width

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  reset; synchronous and active-high
- VecReqM  in  1  vector memory op present in the M stage (MemSrc=1 with MemW or RegWV)
- VecWriteM  in  1  1 = strv, 0 = ldrv; sampled only with VecReqM
- BaseAddrM  in  ADDR_W  ALU result, i.e. the vector base address
- VecWDataM  in  VEC_W  store data from the vector register file
- MemAddr  out  ADDR_W  address of the current beat
- MemWE  out  1  write enable of the current beat
- MemWData  out  WORD_W  write data of the current beat
- MemRData  in  WORD_W  read data; returns one cycle after the address is presented
- VecRData  out  VEC_W  assembled load vector
- VecRValid  out  1  one-cycle pulse; VecRData is valid
- StallVec  out  1  freeze the F, D, E and M stages
- Busy  out  1  FSM not in IDLE

## Operation
- N = VEC_W/WORD_W beats (4 at defaults).
- Beat k transfers bits [k*WORD_W +: WORD_W] at BaseAddr + k*INC. INC is 1 by default.
- Address arithmetic is modulo 2^ADDR_W. Wrap-around is legal and is not flagged.
- States: IDLE, WRITE, READ, DRAIN, DONE.
  - IDLE: on VecReqM, latch the base address, the store data and the op, clear the beat counter, then go to WRITE (strv) or READ (ldrv).
  - WRITE: drive beat k with MemWE=1. After beat N-1, go to DONE.
  - READ: drive beat k address with MemWE=0. Capture MemRData of beat k-1 into lane k-1. After issuing beat N-1, go to DRAIN.
  - DRAIN: capture lane N-1, then go to DONE.
  - DONE: pulse VecRValid for loads only. StallVec=0. Return to IDLE unconditionally; VecReqM is ignored in DONE because M still holds the finished instruction.
- Inputs are latched once. Changes to VecReqM or the data inputs during an operation are ignored.
- Outside WRITE/READ: MemAddr=0, MemWE=0, MemWData=0.
- rst at any cycle, including mid-transfer: go to IDLE and clear all outputs and VecRData to 0. Store beats already written are not rolled back.

## Timing
- StallVec = (IDLE & VecReqM) | WRITE | READ | DRAIN. The IDLE term is combinational, so the stall holds the requesting instruction in the same cycle.
- strv: request at cycle 0, beats in cycles 1..N, DONE at N+1. Stall is high for N+1 cycles.
- ldrv: request at cycle 0, addresses in cycles 1..N, data in cycles 2..N+1, DONE with VecRValid at N+2. Stall is high for N+2 cycles.
- Back-to-back requests: the next request is accepted in the first IDLE cycle after DONE.
- VecRData holds its value until the next load completes or reset.
- Reset values: Busy=0, StallVec=0 (with VecReqM=0), VecRValid=0, VecRData=0, MemWE=0, MemAddr=0, MemWData=0.

## Configuration
- VEC_MEM_BYTE_ADDR_EN defined:
  - memory is byte-addressed; INC = WORD_W/8;
  - the low log2(WORD_W/8) bits of BaseAddrM are forced to 0.
- Not defined: memory is word-addressed; INC = 1; BaseAddrM is used unmodified.

## Structure
- Package vec_mem_pkg holds:
  - default VEC_W, WORD_W, ADDR_W;
  - derived N_BEATS and beat-counter width;
  - the state enum typedef (IDLE, WRITE, READ, DRAIN, DONE).
- One sub-module, vec_word_packer: a lane-indexed capture register that writes WORD_W into lane k on an enable and clears on rst. It is instantiated for VecRData.
- The FSM, beat counter and address generator live in the top module.

## Test plan
- strv, base 0x10, data 0x00112233_44556677_8899AABB_CCDDEEFF -> writes (0x10,0xCCDDEEFF), (0x11,0x8899AABB), (0x12,0x44556677), (0x13,0x00112233) in cycles 1-4; stall is high in cycles 0-4.
- ldrv, base 0x20, memory returns 0xA0,0xA1,0xA2,0xA3 -> VecRValid in cycle 6 with VecRData=0x000000A3_000000A2_000000A1_000000A0.
- ldrv then strv, with VecReqM held high through DONE -> the strv starts on the cycle after DONE, not in DONE; no duplicate load.
- rst asserted in READ cycle 3 -> the next cycle is IDLE; all outputs are 0 and VecRValid never pulses.
- strv, base 0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- VEC_MEM_BYTE_ADDR_EN with base 0x43 -> addresses 0x40, 0x44, 0x48, 0x4C.
